// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, immediate-format encoding and the decoded-field bundle.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // FMT_X marks an opcode outside the supported set: no immediate, no sources.
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        rs1_use;
        logic        rs2_use;
    } dec_t;

    function automatic imm_fmt_e fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                              fmt = FMT_S;
            OP_BRANCH:                             fmt = FMT_B;
            OP_LUI, OP_AUIPC:                      fmt = FMT_U;
            OP_JAL:                                fmt = FMT_J;
            OP_OP:                                 fmt = FMT_R;
            default:                               fmt = FMT_X;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/inst_decode_imm.sv
// Combinational immediate extraction; every format sign-extends from inst_i[31].
module inst_decode_imm
    import rv32i_pkg::*;
(
    input  logic [31:0] inst_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            FMT_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
            FMT_U:   imm_o = {inst_i[31:12], 12'b0};
            FMT_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/inst_decode.sv
// Single registered RV32I decode stage with stall/flush control.
// Optional macro INST_DECODE_ILLEGAL_CHECK_EN enables the D_ILLEGAL encoding check.
module inst_decode
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] PC,
    input  logic        INST_VALID,
    input  logic [31:0] INST,
    output logic        D_VALID,
    output logic [31:0] D_PC,
    output logic [31:0] D_INST,
    output logic [6:0]  D_OPCODE,
    output logic [2:0]  D_FUNCT3,
    output logic [6:0]  D_FUNCT7,
    output logic [4:0]  D_RD,
    output logic [4:0]  D_RS1,
    output logic [4:0]  D_RS2,
    output logic [31:0] D_IMM,
    output logic        D_RS1_USE,
    output logic        D_RS2_USE,
    output logic        D_ILLEGAL
);

    logic [31:0] sel_inst;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    dec_t        dec_d;
    dec_t        dec_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        load_en;

    // Reset, flush and bubbles all decode the NOP word, so one decoder covers every path.
    assign sel_inst = (RST || FLUSH || !INST_VALID) ? NOP_INST : INST;
    assign fmt      = fmt_of(sel_inst[6:0]);
    assign load_en  = RST || FLUSH || !STALL;

    inst_decode_imm u_imm (
        .inst_i (sel_inst),
        .fmt_i  (fmt),
        .imm_o  (imm)
    );

    always_comb begin
        dec_d         = '0;
        dec_d.opcode  = sel_inst[6:0];
        dec_d.funct3  = sel_inst[14:12];
        dec_d.funct7  = sel_inst[31:25];
        dec_d.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : sel_inst[11:7];
        dec_d.rs1     = sel_inst[19:15];
        dec_d.rs2     = sel_inst[24:20];
        dec_d.imm     = imm;
        dec_d.rs1_use = !(fmt == FMT_U || fmt == FMT_J || fmt == FMT_X);
        dec_d.rs2_use = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
    end

    always_ff @(posedge CLK) begin
        if (load_en) begin
            valid_q <= !RST && !FLUSH && INST_VALID;
            inst_q  <= sel_inst;
            dec_q   <= dec_d;
            // PC only advances with a real instruction; bubbles and flushes keep the last one.
            if (RST)
                pc_q <= '0;
            else if (!FLUSH && INST_VALID)
                pc_q <= PC;
        end
    end

`ifdef INST_DECODE_ILLEGAL_CHECK_EN
    logic       illegal_d;
    logic       illegal_q;
    logic [2:0] chk_f3;
    logic [6:0] chk_f7;

    assign chk_f3 = sel_inst[14:12];
    assign chk_f7 = sel_inst[31:25];

    always_comb begin
        illegal_d = 1'b0;
        case (sel_inst[6:0])
            OP_LOAD:   illegal_d = (chk_f3 == 3'b011) || (chk_f3 == 3'b110) || (chk_f3 == 3'b111);
            OP_STORE:  illegal_d = (chk_f3 > 3'b010);
            OP_BRANCH: illegal_d = (chk_f3 == 3'b010) || (chk_f3 == 3'b011);
            OP_JALR:   illegal_d = (chk_f3 != 3'b000);
            OP_OPIMM: begin
                if (chk_f3 == 3'b001)
                    illegal_d = (chk_f7 != 7'h00);
                else if (chk_f3 == 3'b101)
                    illegal_d = (chk_f7 != 7'h00) && (chk_f7 != 7'h20);
            end
            // funct7 0x20 is only meaningful for SUB and SRA.
            OP_OP:     illegal_d = !((chk_f7 == 7'h00) ||
                                     ((chk_f7 == 7'h20) && (chk_f3 == 3'b000 || chk_f3 == 3'b101)));
            OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM: illegal_d = 1'b0;
            default:   illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            illegal_q <= 1'b0;
        else if (load_en)
            illegal_q <= illegal_d;
    end

    assign D_ILLEGAL = illegal_q;
`else
    assign D_ILLEGAL = 1'b0;
`endif

    assign D_VALID   = valid_q;
    assign D_PC      = pc_q;
    assign D_INST    = inst_q;
    assign D_OPCODE  = dec_q.opcode;
    assign D_FUNCT3  = dec_q.funct3;
    assign D_FUNCT7  = dec_q.funct7;
    assign D_RD      = dec_q.rd;
    assign D_RS1     = dec_q.rs1;
    assign D_RS2     = dec_q.rs2;
    assign D_IMM     = dec_q.imm;
    assign D_RS1_USE = dec_q.rs1_use;
    assign D_RS2_USE = dec_q.rs2_use;

endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: expected bundles are queued when stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_inst_decode;

`ifdef INST_DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, STALL, FLUSH, INST_VALID;
    logic [31:0] PC, INST;
    logic        D_VALID, D_RS1_USE, D_RS2_USE, D_ILLEGAL;
    logic [31:0] D_PC, D_INST, D_IMM;
    logic [6:0]  D_OPCODE, D_FUNCT7;
    logic [2:0]  D_FUNCT3;
    logic [4:0]  D_RD, D_RS1, D_RS2;

    always #5 CLK = ~CLK;

    inst_decode #(.NOP_INST(32'h0000_0013)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .PC(PC),
        .INST_VALID(INST_VALID), .INST(INST), .D_VALID(D_VALID), .D_PC(D_PC),
        .D_INST(D_INST), .D_OPCODE(D_OPCODE), .D_FUNCT3(D_FUNCT3), .D_FUNCT7(D_FUNCT7),
        .D_RD(D_RD), .D_RS1(D_RS1), .D_RS2(D_RS2), .D_IMM(D_IMM),
        .D_RS1_USE(D_RS1_USE), .D_RS2_USE(D_RS2_USE), .D_ILLEGAL(D_ILLEGAL)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
        logic        ill;
    } exp_t;

    exp_t tbl [9];
    exp_t model;
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic u1, input logic u2, input logic ill);
        exp_t e;
        e.valid = 1'b1; e.pc = '0; e.inst = inst; e.opcode = op; e.f3 = f3; e.f7 = f7;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.u1 = u1; e.u2 = u2; e.ill = ill;
        return e;
    endfunction

    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic valid, input int idx, input logic [31:0] pc);
        exp_t e;
        exp_t got;
        RST = rst; STALL = stall; FLUSH = flush; INST_VALID = valid;
        INST = tbl[idx].inst; PC = pc;
        if (rst) begin
            e = tbl[0]; e.valid = 1'b0; e.pc = '0; model = e;
        end else if (flush || (!stall && !valid)) begin
            e = tbl[0]; e.valid = 1'b0; e.pc = model.pc; model = e;
        end else if (!stall) begin
            e = tbl[idx]; e.pc = pc; model = e;
        end
        sb_q.push_back(model);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        check("valid",   D_VALID,   got.valid);
        check("pc",      D_PC,      got.pc);
        check("inst",    D_INST,    got.inst);
        check("opcode",  D_OPCODE,  got.opcode);
        check("funct3",  D_FUNCT3,  got.f3);
        check("funct7",  D_FUNCT7,  got.f7);
        check("rd",      D_RD,      got.rd);
        check("rs1",     D_RS1,     got.rs1);
        check("rs2",     D_RS2,     got.rs2);
        check("imm",     D_IMM,     got.imm);
        check("rs1_use", D_RS1_USE, got.u1);
        check("rs2_use", D_RS2_USE, got.u2);
        check("illegal", D_ILLEGAL, got.ill);
        $display("txn rst=%0b stall=%0b flush=%0b v=%0b in=%h -> D_VALID=%0b D_PC=%h D_INST=%h D_IMM=%h",
                 rst, stall, flush, valid, tbl[idx].inst, D_VALID, D_PC, D_INST, D_IMM);
    endtask

    initial begin
        tbl[0] = mk(32'h0000_0013, 7'h13, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h0,        1'b1, 1'b0, 1'b0);
        tbl[1] = mk(32'h0050_0093, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd5,  32'h5,        1'b1, 1'b0, 1'b0);
        tbl[2] = mk(32'hFE20_AE23, 7'h23, 3'd2, 7'h7F, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        tbl[3] = mk(32'hFE00_0CE3, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(32'h1234_52B7, 7'h37, 3'd5, 7'h09, 5'd5,  5'd8,  5'd3,  32'h1234_5000, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(32'hFFFF_FFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'h0,        1'b0, 1'b0, ILL_EN);
        tbl[6] = mk(32'h0080_00EF, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd8,  32'h8,        1'b0, 1'b0, 1'b0);
        tbl[7] = mk(32'h40B5_0533, 7'h33, 3'd0, 7'h20, 5'd10, 5'd10, 5'd11, 32'h0,        1'b1, 1'b1, 1'b0);
        tbl[8] = mk(32'h40B5_1533, 7'h33, 3'd1, 7'h20, 5'd10, 5'd10, 5'd11, 32'h0,        1'b1, 1'b1, ILL_EN);
        model = tbl[0];

        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 1, 32'h4);
        step(0, 0, 0, 1, 1, 32'h100);
        step(0, 0, 0, 1, 2, 32'h104);
        step(0, 0, 0, 1, 3, 32'h108);
        step(0, 0, 0, 1, 4, 32'h10C);
        step(0, 0, 0, 1, 6, 32'h110);
        step(0, 0, 0, 1, 7, 32'h114);
        step(0, 0, 0, 1, 8, 32'h118);
        step(0, 0, 0, 1, 5, 32'h11C);
        step(0, 0, 0, 0, 3, 32'h200);
        step(0, 0, 0, 1, 2, 32'h120);
        step(0, 1, 0, 1, 4, 32'h124);
        step(0, 1, 0, 1, 6, 32'h128);
        step(0, 1, 0, 0, 7, 32'h12C);
        step(0, 1, 1, 1, 1, 32'h130);
        step(0, 0, 0, 1, 4, 32'h134);
        step(0, 0, 1, 1, 2, 32'h138);
        step(0, 0, 0, 1, 3, 32'h13C);
        step(0, 1, 0, 1, 2, 32'h140);
        step(1, 1, 0, 1, 3, 32'h144);
        step(0, 0, 0, 1, 5, 32'h148);
        step(1, 1, 1, 1, 7, 32'h14C);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 8)), 32'h1000 + 32'(i * 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
